// File: rtl/merge_pkg.sv
// merge_pkg: token bundle and lane helpers shared by merge_lanes.
// Field widths match the default top-level parameters.
package merge_pkg;

    localparam int OC_W      = 5;
    localparam int PV_W      = 15;
    localparam int PC_W      = 4;
    localparam int ZC_W      = 5;
    localparam int BV_W      = 9;
    localparam int BC_W      = 4;
    localparam int MAX_LANES = 16;

    typedef struct packed {
        logic [OC_W-1:0] oc;
        logic [PV_W-1:0] pv;
        logic [PC_W-1:0] pc;
        logic [ZC_W-1:0] zc;
        logic [BV_W-1:0] bv;
        logic [BC_W-1:0] bc;
    } token_t;

    function automatic logic [4:0] popcount_lanes(
        input logic [MAX_LANES-1:0] v
    );
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/merge_lane.sv
// merge_lane: one lane of merge_lanes; HOLD=1 holds the latest token
// until the tick, HOLD=0 passes only tick-cycle tokens.
module merge_lane
    import merge_pkg::*;
#(
    parameter bit HOLD = 1'b1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   et,
    input  logic   vl,
    input  token_t tk,
    output logic   o_vl,
    output token_t o_tk,
    output logic   o_col,
    output logic   vl_nxt,
    output logic   col_nxt
);

    token_t tk_nxt;

    if (HOLD) begin : g_hold
        logic   held;
        token_t held_tk;

        always_comb begin
            col_nxt = vl & held;
            vl_nxt  = et & (vl | held);
            tk_nxt  = vl ? tk : held_tk;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                held <= 1'b0;
            end else if (et) begin
                held <= 1'b0;
            end else if (vl) begin
                held <= 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (!et && vl) begin
                held_tk <= tk;
            end
        end
    end else begin : g_pass
        // A token that misses the tick has nowhere to go.
        always_comb begin
            col_nxt = vl & ~et;
            vl_nxt  = et & vl;
            tk_nxt  = tk;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_vl  <= 1'b0;
            o_col <= 1'b0;
        end else begin
            o_vl  <= vl_nxt;
            o_col <= col_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (et) begin
            o_tk <= tk_nxt;
        end
    end

endmodule

// File: rtl/merge_lanes.sv
// merge_lanes: holds per-lane tokens and releases them together on i_et.
// Define MERGE_ERR_CNT_EN to build the saturating collision counter.
module merge_lanes
    import merge_pkg::*;
#(
    parameter int NLANE     = 8,
    parameter int OCW       = OC_W,
    parameter int PVW       = PV_W,
    parameter int PCW       = PC_W,
    parameter int ZCW       = ZC_W,
    parameter int BVW       = BV_W,
    parameter int BCW       = BC_W,
    parameter int HOLD_LAST = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_et,
    input  logic                       i_vl [1:NLANE],
    input  token_t                     i_tk [1:NLANE],
    output logic                       o_vl [1:NLANE],
    output token_t                     o_tk [1:NLANE],
    output logic [$clog2(NLANE+1)-1:0] o_cnt,
    output logic                       o_col,
    output logic                       o_err,
    output logic [15:0]                o_err_cnt
);

    localparam int CW  = $clog2(NLANE + 1);
    localparam int TKW = OCW + PVW + PCW + ZCW + BVW + BCW;

    // Token layout is fixed by the package; this block only exists
    // when the width parameters disagree with it.
    if (TKW != $bits(token_t)) begin : g_tkw_mismatch
    end

    logic [MAX_LANES-1:0] vl_nxt;
    logic [MAX_LANES-1:0] col_nxt;
    logic [MAX_LANES-1:0] col_q;

    for (genvar l = 1; l <= NLANE; l++) begin : g_lane
        merge_lane #(
            .HOLD(l < NLANE || HOLD_LAST != 0)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .et     (i_et),
            .vl     (i_vl[l]),
            .tk     (i_tk[l]),
            .o_vl   (o_vl[l]),
            .o_tk   (o_tk[l]),
            .o_col  (col_q[l-1]),
            .vl_nxt (vl_nxt[l-1]),
            .col_nxt(col_nxt[l-1])
        );
    end

    for (genvar i = NLANE; i < MAX_LANES; i++) begin : g_pad
        assign vl_nxt[i]  = 1'b0;
        assign col_nxt[i] = 1'b0;
        assign col_q[i]   = 1'b0;
    end

    assign o_col = |col_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            o_cnt <= '0;
            o_err <= 1'b0;
        end else begin
            o_cnt <= CW'(popcount_lanes(vl_nxt));
            if (|col_nxt) begin
                o_err <= 1'b1;
            end
        end
    end

`ifdef MERGE_ERR_CNT_EN
    logic [16:0] err_sum;

    assign err_sum = {1'b0, o_err_cnt}
                   + 17'(popcount_lanes(col_nxt));

    always_ff @(posedge clk) begin
        if (rst) begin
            o_err_cnt <= '0;
        end else begin
            o_err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end
`else
    assign o_err_cnt = '0;
`endif

endmodule

// File: tb/tb_merge_lanes.sv
// tb_merge_lanes: drives two merge_lanes (HOLD_LAST 0 and 1) with
// directed vectors and checks them against a lane-rule model.
module tb_merge_lanes;
    import merge_pkg::*;

    localparam int NL = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic   rst;
    logic   et;
    logic   vl [1:NL];
    token_t tk [1:NL];

    logic        vl0 [1:NL];
    logic        vl1 [1:NL];
    token_t      tk0 [1:NL];
    token_t      tk1 [1:NL];
    logic [3:0]  cnt0, cnt1;
    logic        col0, col1, err0, err1;
    logic [15:0] ec0, ec1;

    merge_lanes #(.NLANE(NL), .HOLD_LAST(0)) dut0 (
        .clk(clk), .rst(rst), .i_et(et), .i_vl(vl), .i_tk(tk),
        .o_vl(vl0), .o_tk(tk0), .o_cnt(cnt0), .o_col(col0),
        .o_err(err0), .o_err_cnt(ec0)
    );

    merge_lanes #(.NLANE(NL), .HOLD_LAST(1)) dut1 (
        .clk(clk), .rst(rst), .i_et(et), .i_vl(vl), .i_tk(tk),
        .o_vl(vl1), .o_tk(tk1), .o_cnt(cnt1), .o_col(col1),
        .o_err(err1), .o_err_cnt(ec1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model: held flag/token per lane and expected outputs per instance.
    logic   mh  [2][1:NL];
    token_t mt  [2][1:NL];
    logic   xv  [2][1:NL];
    token_t xt  [2][1:NL];
    int     xcnt [2];
    logic   xcol [2];
    logic   xerr [2];
    int     xec  [2];

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            int ne;
            int nv;
            ne = 0;
            nv = 0;
            if (rst) begin
                for (int l = 1; l <= NL; l++) begin
                    mh[m][l] <= 1'b0;
                    xv[m][l] <= 1'b0;
                end
                xcnt[m] <= 0;
                xcol[m] <= 1'b0;
                xerr[m] <= 1'b0;
                xec[m]  <= 0;
            end else begin
                for (int l = 1; l <= NL; l++) begin
                    if (l < NL || m == 1) begin
                        if (vl[l] && mh[m][l]) ne++;
                        if (et) begin
                            xv[m][l] <= vl[l] | mh[m][l];
                            xt[m][l] <= vl[l] ? tk[l] : mt[m][l];
                            mh[m][l] <= 1'b0;
                            if (vl[l] || mh[m][l]) nv++;
                        end else begin
                            xv[m][l] <= 1'b0;
                            if (vl[l]) begin
                                mh[m][l] <= 1'b1;
                                mt[m][l] <= tk[l];
                            end
                        end
                    end else begin
                        if (vl[l] && !et) ne++;
                        xv[m][l] <= et & vl[l];
                        if (et) xt[m][l] <= tk[l];
                        if (et && vl[l]) nv++;
                    end
                end
                xcnt[m] <= nv;
                xcol[m] <= (ne > 0);
                if (ne > 0) xerr[m] <= 1'b1;
`ifdef MERGE_ERR_CNT_EN
                xec[m] <= (xec[m] + ne > 65535) ? 65535 : xec[m] + ne;
`else
                xec[m] <= 0;
`endif
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int m = 0; m < 2; m++) begin
                for (int l = 1; l <= NL; l++) begin
                    logic   av;
                    token_t at;
                    av = (m == 0) ? vl0[l] : vl1[l];
                    at = (m == 0) ? tk0[l] : tk1[l];
                    chk($sformatf("m%0d_vl%0d", m, l), 64'(av),
                        64'(xv[m][l]));
                    if (xv[m][l]) begin
                        chk($sformatf("m%0d_tk%0d", m, l), 64'(at),
                            64'(xt[m][l]));
                    end
                end
                chk($sformatf("m%0d_cnt", m),
                    64'(m == 0 ? cnt0 : cnt1), 64'(xcnt[m]));
                chk($sformatf("m%0d_col", m),
                    64'(m == 0 ? col0 : col1), 64'(xcol[m]));
                chk($sformatf("m%0d_err", m),
                    64'(m == 0 ? err0 : err1), 64'(xerr[m]));
                chk($sformatf("m%0d_ecnt", m),
                    64'(m == 0 ? ec0 : ec1), 64'(xec[m]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        for (int l = 1; l <= NL; l++) begin
            vl[l] = 1'b0;
            tk[l] = '0;
        end
    endtask

    task automatic put(input int l, input logic [14:0] pv);
        vl[l]    = 1'b1;
        tk[l].oc = 5'(l);
        tk[l].pv = pv;
        tk[l].pc = 4'(l);
        tk[l].zc = 5'(l + 3);
        tk[l].bv = 9'(l * 7);
        tk[l].bc = 4'(~l);
    endtask

    task automatic put_n(input int n);
        for (int l = 1; l <= n; l++) put(l, 15'(16'h0100 + l));
    endtask

    function automatic int sum_vl0();
        int s;
        s = 0;
        for (int l = 1; l <= NL; l++) s += int'(vl0[l]);
        return s;
    endfunction

    initial begin
        int k;
        rst = 1'b1;
        et  = 1'b0;
        clr();
        step();
        step();
        chk_en = 1'b1;
        chk("rst_cnt", 64'(cnt0), 64'd0);
        chk("rst_col", 64'(col0), 64'd0);
        chk("rst_err", 64'(err0), 64'd0);
        chk("rst_ecnt", 64'(ec0), 64'd0);
        chk("rst_vl", 64'(sum_vl0()), 64'd0);
        rst = 1'b0;

        // single held token released by the tick
        put(3, 15'h1234);
        step();
        clr();
        step();
        step();
        et = 1'b1;
        step();
        et = 1'b0;
        chk("t1_vl3", 64'(vl0[3]), 64'd1);
        chk("t1_pv3", 64'(tk0[3].pv), 64'h1234);
        chk("t1_cnt", 64'(cnt0), 64'd1);
        chk("t1_nvl", 64'(sum_vl0()), 64'd1);
        chk("t1_model", 64'(xcnt[0]), 64'd1);

        // overwrite while held: last write wins, collision reported
        put(2, 15'h0011);
        step();
        put(2, 15'h0022);
        step();
        clr();
        chk("t2_col", 64'(col0), 64'd1);
        step();
        chk("t2_col_end", 64'(col0), 64'd0);
        chk("t2_err", 64'(err0), 64'd1);
        et = 1'b1;
        step();
        et = 1'b0;
        chk("t2_vl2", 64'(vl0[2]), 64'd1);
        chk("t2_pv2", 64'(tk0[2].pv), 64'h0022);
`ifdef MERGE_ERR_CNT_EN
        chk("t2_ecnt", 64'(ec0), 64'd1);
`else
        chk("t2_ecnt", 64'(ec0), 64'd0);
`endif

        // last lane: pass mode drops, hold mode keeps
        rst = 1'b1;
        step();
        rst = 1'b0;
        put(8, 15'h0100);
        step();
        clr();
        chk("t3_vl8_m0", 64'(vl0[8]), 64'd0);
        chk("t3_col_m0", 64'(col0), 64'd1);
        chk("t3_col_m1", 64'(col1), 64'd0);
        step();
        put(8, 15'h7FFF);
        et = 1'b1;
        step();
        clr();
        et = 1'b0;
        chk("t3_vl8_m0b", 64'(vl0[8]), 64'd1);
        chk("t3_pv8_m0", 64'(tk0[8].pv), 64'h7FFF);
        chk("t3_vl8_m1", 64'(vl1[8]), 64'd1);
        chk("t3_pv8_m1", 64'(tk1[8].pv), 64'h7FFF);

        // all lanes on the tick, then an empty tick
        put_n(NL);
        et = 1'b1;
        step();
        clr();
        chk("t4_cnt_m0", 64'(cnt0), 64'd8);
        chk("t4_cnt_m1", 64'(cnt1), 64'd8);
        chk("t4_nvl", 64'(sum_vl0()), 64'd8);
        chk("t4_col_m0", 64'(col0), 64'd0);
        chk("t4_col_m1", 64'(col1), 64'd0);
        step();
        et = 1'b0;
        chk("t4_cnt2_m0", 64'(cnt0), 64'd0);
        chk("t4_cnt2_m1", 64'(cnt1), 64'd0);

        // reset mid-group discards held tokens
        put(1, 15'h0aaa);
        put(5, 15'h0555);
        step();
        clr();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        et = 1'b1;
        step();
        et = 1'b0;
        chk("t5_nvl", 64'(sum_vl0()), 64'd0);
        chk("t5_cnt", 64'(cnt0), 64'd0);
        chk("t5_err_m0", 64'(err0), 64'd0);
        chk("t5_err_m1", 64'(err1), 64'd0);

`ifdef MERGE_ERR_CNT_EN
        // walk the counter up to its saturation point
        while (xec[0] < 65520) begin
            put_n(NL);
            step();
        end
        while (xec[0] < 65534) begin
            k = (65534 - xec[0] > 7) ? 7 : 65534 - xec[0];
            clr();
            put_n(k);
            step();
        end
        clr();
        chk("t6_fffe", 64'(ec0), 64'hFFFE);
        put_n(3);
        step();
        chk("t6_ffff", 64'(ec0), 64'hFFFF);
        put_n(NL);
        step();
        step();
        clr();
        chk("t6_hold_m0", 64'(ec0), 64'hFFFF);
        chk("t6_hold_m1", 64'(ec1), 64'hFFFF);
`else
        put_n(NL);
        step();
        step();
        clr();
        chk("t6_tied", 64'(ec0), 64'd0);
`endif
        step();
        et = 1'b1;
        step();
        et = 1'b0;
        step();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
